// File: rtl/alk_pkg.sv
// Shared encodings and iteration constants for the mul/div sequencer.
package alk_pkg;

    typedef enum logic [1:0] {
        OP_MUL  = 2'b00,
        OP_DIV  = 2'b01,
        OP_DIVD = 2'b10,
        OP_REM  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        SIZE_BYTE     = 2'b00,
        SIZE_WORD     = 2'b01,
        SIZE_LONG     = 2'b10,
        SIZE_LONG_ALT = 2'b11
    } size_e;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_INIT  = 3'd1,
        ST_LOOP  = 3'd2,
        ST_FIXUP = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

    localparam int         CNT_W     = 7;
    localparam logic [6:0] ITER_BYTE = 7'd8;
    localparam logic [6:0] ITER_WORD = 7'd16;
    localparam logic [6:0] ITER_LONG = 7'd32;
    localparam logic [6:0] ITER_DIVD = 7'd64;

    // Iteration count for an op; the 64-bit dividend form ignores size.
    function automatic logic [6:0] iter_count(input op_e op, input size_e size);
        logic [6:0] n;
        if (op == OP_DIVD) begin
            n = ITER_DIVD;
        end else begin
            case (size)
                SIZE_BYTE: n = ITER_BYTE;
                SIZE_WORD: n = ITER_WORD;
                default:   n = ITER_LONG;
            endcase
        end
        return n;
    endfunction

endpackage

// File: rtl/alk_iter_ctr.sv
// Loadable 7-bit iteration down-counter; holds at zero rather than wrapping.
module alk_iter_ctr
    import alk_pkg::*;
(
    input  logic             clk_h,
    input  logic             reset_h,
    input  logic             load_h,
    input  logic [CNT_W-1:0] load_val_h,
    input  logic             en_h,
    output logic [CNT_W-1:0] count_h,
    output logic             is_one_h,
    output logic             zero_h
);

    logic [CNT_W-1:0] count_q;

    // Load takes priority over decrement; a stale enable at zero is ignored.
    always_ff @(posedge clk_h or posedge reset_h) begin
        if (reset_h) begin
            count_q <= '0;
        end else if (load_h) begin
            count_q <= load_val_h;
        end else if (en_h && (count_q != '0)) begin
            count_q <= count_q - 1'b1;
        end
    end

    assign count_h  = count_q;
    assign is_one_h = (count_q == 7'd1);
    assign zero_h   = (count_q == '0);

endmodule

// File: rtl/alk_muldiv_seq.sv
// Multiply/divide microsequencer: walks INIT -> LOOP -> (FIXUP) -> DONE.
//
//   state    | meaning
//   ---------+------------------------------------------------------
//   ST_IDLE  | waiting for start_h; op latched and counter loaded on exit
//   ST_INIT  | one setup cycle before the iteration loop
//   ST_LOOP  | one iteration per unstalled cycle, counter counts N..1
//   ST_FIXUP | quotient/remainder correction (all ops except MUL)
//   ST_DONE  | one-cycle completion strobe
module alk_muldiv_seq
    import alk_pkg::*;
(
    input  logic       clk_h,
    input  logic       reset_h,
    input  logic       start_h,
    input  logic [1:0] op_h,
    input  logic [1:0] size_h,
    input  logic       stall_h,
    input  logic       abort_h,
    output logic       loop_flag_h,
    output logic       busy_h,
    output logic       fixup_h,
    output logic       done_h,
    output logic [6:0] count_h,
    output logic [1:0] op_q_h
);

    state_e           state_q;
    state_e           state_d;
    op_e              op_q;
    logic             ctr_load;
    logic             ctr_en;
    logic             ctr_is_one;
    logic             ctr_zero;
    logic [CNT_W-1:0] ctr_load_val;

    // Size only matters for the iteration count, so it is captured as the
    // counter's load value rather than held in a separate register.
    assign ctr_load_val = iter_count(op_e'(op_h), size_e'(size_h));

    alk_iter_ctr u_iter_ctr (
        .clk_h      (clk_h),
        .reset_h    (reset_h),
        .load_h     (ctr_load),
        .load_val_h (ctr_load_val),
        .en_h       (ctr_en),
        .count_h    (count_h),
        .is_one_h   (ctr_is_one),
        .zero_h     (ctr_zero)
    );

    // State register.
    always_ff @(posedge clk_h or posedge reset_h) begin
        if (reset_h) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Op latch, captured on the same edge that accepts start.
    always_ff @(posedge clk_h or posedge reset_h) begin
        if (reset_h) begin
            op_q <= OP_MUL;
        end else if (ctr_load) begin
            op_q <= op_e'(op_h);
        end
    end

    // Next-state and counter control; abort beats stall and start.
    always_comb begin
        state_d  = state_q;
        ctr_load = 1'b0;
        ctr_en   = 1'b0;
        if (abort_h) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start_h) begin
                        state_d  = ST_INIT;
                        ctr_load = 1'b1;
                    end
                end
                ST_INIT: begin
                    if (!stall_h) state_d = ST_LOOP;
                end
                ST_LOOP: begin
                    if (!stall_h) begin
                        ctr_en = !ctr_zero;
                        if (ctr_is_one || ctr_zero) begin
                            state_d = (op_q == OP_MUL) ? ST_DONE : ST_FIXUP;
                        end
                    end
                end
                ST_FIXUP: begin
                    if (!stall_h) state_d = ST_DONE;
                end
                ST_DONE: begin
                    if (!stall_h) state_d = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    assign loop_flag_h = (state_q == ST_LOOP);
    assign busy_h      = (state_q != ST_IDLE);
    assign fixup_h     = (state_q == ST_FIXUP);
    assign done_h      = (state_q == ST_DONE);
    assign op_q_h      = op_q;

endmodule

// File: tb/tb_alk_muldiv_seq.sv
// Self-checking bench for alk_muldiv_seq: table vectors, corner sequences,
// and randomized ops with stalls against an expected-trace model.
module tb_alk_muldiv_seq;

    logic       clk_h = 1'b0;
    logic       reset_h;
    logic       start_h;
    logic [1:0] op_h;
    logic [1:0] size_h;
    logic       stall_h;
    logic       abort_h;
    logic       loop_flag_h;
    logic       busy_h;
    logic       fixup_h;
    logic       done_h;
    logic [6:0] count_h;
    logic [1:0] op_q_h;

    int n_pass = 0;
    int n_chk  = 0;

    alk_muldiv_seq dut (
        .clk_h       (clk_h),
        .reset_h     (reset_h),
        .start_h     (start_h),
        .op_h        (op_h),
        .size_h      (size_h),
        .stall_h     (stall_h),
        .abort_h     (abort_h),
        .loop_flag_h (loop_flag_h),
        .busy_h      (busy_h),
        .fixup_h     (fixup_h),
        .done_h      (done_h),
        .count_h     (count_h),
        .op_q_h      (op_q_h)
    );

    always #5 clk_h = ~clk_h;

    typedef struct {
        logic       loop_f;
        logic       busy;
        logic       fixup;
        logic       done;
        logic [6:0] count;
    } exp_t;

    typedef struct {
        logic [1:0] op;
        logic [1:0] size;
        int         n;
        int         done_cyc;
    } vec_t;

    exp_t trace[$];
    exp_t idle_e = '{1'b0, 1'b0, 1'b0, 1'b0, 7'd0};

    task automatic check_outs(input string name, input exp_t e, input logic [1:0] op);
        n_chk++;
        if ({loop_flag_h, busy_h, fixup_h, done_h, count_h, op_q_h} ===
            {e.loop_f, e.busy, e.fixup, e.done, e.count, op}) begin
            n_pass++;
        end else begin
            $display("FAIL %s t=%0t: got loop=%b busy=%b fixup=%b done=%b count=%0d op_q=%0d want loop=%b busy=%b fixup=%b done=%b count=%0d op_q=%0d",
                     name, $time, loop_flag_h, busy_h, fixup_h, done_h, count_h, op_q_h,
                     e.loop_f, e.busy, e.fixup, e.done, e.count, op);
        end
    endtask

    task automatic check_val(input string name, input int got, input int want);
        n_chk++;
        if (got == want) n_pass++;
        else $display("FAIL %s t=%0t: got %0d want %0d", name, $time, got, want);
    endtask

    // Expected per-cycle outputs from the start edge to DONE.
    task automatic build_trace(input logic [1:0] op, input int n);
        trace.delete();
        trace.push_back('{1'b0, 1'b1, 1'b0, 1'b0, 7'(n)});
        for (int i = 0; i < n; i++) trace.push_back('{1'b1, 1'b1, 1'b0, 1'b0, 7'(n - i)});
        if (op != 2'b00) trace.push_back('{1'b0, 1'b1, 1'b1, 1'b0, 7'd0});
        trace.push_back('{1'b0, 1'b1, 1'b0, 1'b1, 7'd0});
    endtask

    task automatic tick();
        @(posedge clk_h);
        #1;
    endtask

    // Runs one op to completion; stalls advance nothing in the model.
    task automatic run_op(input logic [1:0] op, input logic [1:0] size, input int n,
                          input bit rnd_stall, input int stall_cnt, input int stall_len,
                          output int done_cyc);
        int p;
        int cyc;
        int stalls;
        bit st;
        build_trace(op, n);
        op_h    = op;
        size_h  = size;
        abort_h = 1'b0;
        start_h = 1'b1;
        stall_h = 1'($urandom_range(0, 1));
        tick();
        start_h  = 1'b0;
        stall_h  = 1'b0;
        cyc      = 1;
        p        = 0;
        stalls   = 0;
        done_cyc = -1;
        check_outs("init", trace[0], op);
        forever begin
            st = 1'b0;
            if (rnd_stall && $urandom_range(0, 3) == 0) st = 1'b1;
            if (stall_cnt != 0 && trace[p].loop_f && trace[p].count == 7'(stall_cnt) &&
                stalls < stall_len) begin
                st = 1'b1;
                stalls++;
            end
            stall_h = st;
            start_h = 1'($urandom_range(0, 1));
            op_h    = 2'($urandom);
            size_h  = 2'($urandom);
            tick();
            cyc++;
            if (!st) p++;
            if (p == trace.size()) begin
                start_h = 1'b0;
                stall_h = 1'b0;
                check_outs("idle_after", idle_e, op);
                break;
            end
            check_outs("trace", trace[p], op);
            if (trace[p].done && done_cyc < 0) done_cyc = cyc;
            if (cyc > 1000) begin
                check_val("run_timeout", cyc, -1);
                start_h = 1'b0;
                stall_h = 1'b0;
                break;
            end
        end
    endtask

    initial begin
        vec_t vecs[8];
        int   dc;
        vecs[0] = '{2'b00, 2'b10, 32, 34};
        vecs[1] = '{2'b11, 2'b00,  8, 11};
        vecs[2] = '{2'b10, 2'b00, 64, 67};
        vecs[3] = '{2'b01, 2'b10, 32, 35};
        vecs[4] = '{2'b00, 2'b01, 16, 18};
        vecs[5] = '{2'b01, 2'b11, 32, 35};
        vecs[6] = '{2'b11, 2'b01, 16, 19};
        vecs[7] = '{2'b10, 2'b10, 64, 67};

        reset_h = 1'b1;
        start_h = 1'b0;
        stall_h = 1'b0;
        abort_h = 1'b0;
        op_h    = 2'b11;
        size_h  = 2'b00;
        #11;
        check_outs("reset_state", idle_e, 2'b00);
        #1;
        reset_h = 1'b0;

        // First entry starts on the first edge after reset release.
        foreach (vecs[i]) begin
            run_op(vecs[i].op, vecs[i].size, vecs[i].n, 1'b0, 0, 0, dc);
            check_val($sformatf("latency_vec%0d", i), dc, vecs[i].done_cyc);
        end

        // DIV long with a 5-cycle stall while the count sits at 17.
        run_op(2'b01, 2'b10, 32, 1'b0, 17, 5, dc);
        check_val("stall17_latency", dc, 40);

        // Abort together with stall in LOOP at count 10.
        op_h = 2'b00; size_h = 2'b01; start_h = 1'b1;
        tick();
        start_h = 1'b0;
        repeat (7) tick();
        check_outs("pre_abort", '{1'b1, 1'b1, 1'b0, 1'b0, 7'd10}, 2'b00);
        abort_h = 1'b1; stall_h = 1'b1;
        tick();
        abort_h = 1'b0; stall_h = 1'b0;
        check_val("abort_idle", int'({loop_flag_h, busy_h, fixup_h, done_h}), 0);
        op_h = 2'b01; size_h = 2'b00; start_h = 1'b1;
        tick();
        start_h = 1'b0;
        check_outs("start_after_abort", '{1'b0, 1'b1, 1'b0, 1'b0, 7'd8}, 2'b01);
        abort_h = 1'b1;
        tick();
        abort_h = 1'b0;
        check_val("abort_init", int'(busy_h), 0);
        start_h = 1'b1; abort_h = 1'b1;
        tick();
        start_h = 1'b0; abort_h = 1'b0;
        check_val("start_with_abort", int'(busy_h), 0);

        // Async reset between edges during FIXUP of a REM byte op.
        op_h = 2'b11; size_h = 2'b00; start_h = 1'b1;
        tick();
        start_h = 1'b0;
        repeat (9) tick();
        check_outs("fixup_reached", '{1'b0, 1'b1, 1'b1, 1'b0, 7'd0}, 2'b11);
        #2 reset_h = 1'b1;
        #1 check_outs("async_reset", idle_e, 2'b00);
        #1 reset_h = 1'b0;
        tick();
        check_outs("post_reset_idle", idle_e, 2'b00);

        // Randomized ops with random stalls and start noise.
        for (int k = 0; k < 20; k++) begin
            logic [1:0] rop;
            logic [1:0] rsz;
            int         rn;
            rop = 2'($urandom_range(0, 3));
            rsz = 2'($urandom_range(0, 3));
            if (rop == 2'b10) rn = 64;
            else if (rsz >= 2'b10) rn = 32;
            else if (rsz == 2'b01) rn = 16;
            else rn = 8;
            run_op(rop, rsz, rn, 1'b1, 0, 0, dc);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/alk_muldiv_seq.md
ALK_MULDIV_SEQ -- requirements
Module: alk_muldiv_seq

Interface
REQ-001 SHALL have one clock and an asynchronous active-high reset; no other clock or reset inputs.
REQ-002 clk_h  in  1  single clock; all state changes on rising edge.
REQ-003 reset_h  in  1  asynchronous, active-high reset.
REQ-004 start_h  in  1  begin op; sampled only in IDLE.
REQ-005 op_h  in  2  operation: 00 MUL, 01 DIV, 10 DIVD, 11 REM; latched at start.
REQ-006 size_h  in  2  operand size: 00 byte (8 iterations), 01 word (16), 10 long (32), 11 treated as long; latched at start.
REQ-007 stall_h  in  1  microsequencer stall; freezes the sequencer.
REQ-008 abort_h  in  1  cancel the operation in progress.
REQ-009 loop_flag_h  out  1  high during LOOP; qualifies the fast MUL/DIV ALPCTL cycles.
REQ-010 busy_h  out  1  high in INIT, LOOP, FIXUP and DONE.
REQ-011 fixup_h  out  1  high in FIXUP (remainder/quotient correction cycle).
REQ-012 done_h  out  1  high in DONE.
REQ-013 count_h  out  7  iterations remaining.
REQ-014 op_q_h  out  2  latched op; drives mul/div ALPCTL selection downstream.

Function
REQ-015 States SHALL be IDLE, INIT, LOOP, FIXUP and DONE.
REQ-016 IDLE: if start_h=1 and abort_h=0, SHALL go to INIT next edge, latch op_h and size_h, and load count_h with N; otherwise stay in IDLE.
REQ-017 N SHALL be 8/16/32 per size_q for MUL, DIV and REM; DIVD SHALL use N=64 regardless of size.
REQ-018 INIT: lasts exactly one unstalled cycle; busy_h=1, loop_flag_h=0; then goes to LOOP.
REQ-019 LOOP: loop_flag_h=1; count_h SHALL decrement by 1 on each unstalled cycle.
REQ-020 LOOP exit: on the unstalled cycle with count_h=1, go to DONE if op_q=MUL, else to FIXUP; count_h becomes 0.
REQ-021 FIXUP: lasts one unstalled cycle with fixup_h=1; then goes to DONE.
REQ-022 DONE: lasts one unstalled cycle with done_h=1; then goes to IDLE.
REQ-023 stall_h=1 outside IDLE SHALL freeze state and count_h and hold all outputs; stall_h SHALL be ignored in IDLE.
REQ-024 abort_h=1 in any state SHALL force IDLE on the next edge; done_h is not asserted; abort_h overrides stall_h and start_h.
REQ-025 start_h outside IDLE SHALL be ignored, with no requeue.
REQ-026 Latency, unstalled, long size: MUL done_h occurs 34 cycles after the start edge; DIV and REM 35 cycles; DIVD 67 cycles.
REQ-027 All outputs SHALL be registered or decoded from the state register only, with no combinational path from inputs.

Reset
REQ-028 Reset SHALL force IDLE; loop_flag_h, busy_h, fixup_h and done_h = 0; count_h = 0; op_q_h = 00.
REQ-029 Reset asserted mid-operation SHALL abandon the op immediately, without waiting for a clock edge.
REQ-030 First start_h SHALL be honoured on the first edge after reset deassertion.

Structure
REQ-031 Shared package alk_pkg SHALL hold the op encodings, the size encodings, the state encoding and the iteration constants (8, 16, 32, 64).
REQ-032 The iteration counter SHALL be a sub-module alk_iter_ctr: loadable 7-bit down-counter with load, enable, is_one and zero outputs.
REQ-033 alk_muldiv_seq SHALL contain the FSM and the op/size latches only.

Verification
REQ-034 MUL, size=10, no stall: start pulse -> INIT for 1 cycle; loop_flag_h for 32 cycles (count_h 32 down to 1); done_h in the next cycle; fixup_h never asserted.
REQ-035 REM, size=00: start -> 8 LOOP cycles, then 1 FIXUP cycle, then 1 DONE cycle; done_h at cycle 11 after start.
REQ-036 DIVD with size=00: count_h loads 64; done_h at cycle 67.
REQ-037 DIV long, stall_h high for 5 cycles when count_h=17 -> count_h holds 17 for those 5 cycles; done_h 5 cycles later than the REQ-026 latency.
REQ-038 abort_h with stall_h during LOOP (count_h=10) -> IDLE next edge with done_h=0; start_h one cycle later is accepted.
REQ-039 Async reset pulsed between edges during FIXUP -> outputs go to their reset values before the next edge; start_h during LOOP has no effect.
